// File: rtl/lifm_lowering_feeder_pkg.sv
// Shared definitions for the LIFM lowering feeder and the redundancy controller:
// default sizes, feeder FSM encoding and helpers to read/write one slot of a packed line.
package lifm_lowering_feeder_pkg;

    localparam int LF_WORD_WIDTH = 8;
    localparam int LF_MAX_R_SIZE = 4;
    localparam int LF_ADDR_WIDTH = 16;
    localparam int LF_LINE_WIDTH = LF_MAX_R_SIZE * LF_WORD_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_FETCH,
        ST_DRAIN,
        ST_OUT,
        ST_FIN
    } feeder_state_t;

    // Slot r of a packed line lives at bits [r*WORD_WIDTH +: WORD_WIDTH].
    function automatic logic [LF_WORD_WIDTH-1:0] line_slot_get(
        input logic [LF_LINE_WIDTH-1:0] line,
        input int                       r
    );
        return line[r*LF_WORD_WIDTH +: LF_WORD_WIDTH];
    endfunction

    function automatic logic [LF_LINE_WIDTH-1:0] line_slot_set(
        input logic [LF_LINE_WIDTH-1:0] line,
        input int                       r,
        input logic [LF_WORD_WIDTH-1:0] word
    );
        logic [LF_LINE_WIDTH-1:0] result;
        result = line;
        result[r*LF_WORD_WIDTH +: LF_WORD_WIDTH] = word;
        return result;
    endfunction

endpackage

// File: rtl/lifm_lowering_feeder_if.sv
// Column stream from the feeder to the redundancy controller: index, packed line and
// slot mask qualified by a valid/ready handshake.
interface lifm_lowering_feeder_if
    import lifm_lowering_feeder_pkg::*;
#(
    parameter int WORD_WIDTH = LF_WORD_WIDTH,
    parameter int MAX_R_SIZE = LF_MAX_R_SIZE
);
    logic                             out_valid;
    logic                             out_ready;
    logic [WORD_WIDTH-1:0]            idx;
    logic [MAX_R_SIZE*WORD_WIDTH-1:0] lifm_line;
    logic [MAX_R_SIZE-1:0]            line_mask;

    modport master (output out_valid, idx, lifm_line, line_mask, input out_ready);
    modport slave  (input out_valid, idx, lifm_line, line_mask, output out_ready);
endinterface

// File: rtl/lifm_lowering_feeder_pos_stepper.sv
// Walks the output positions of a tile in raster order, one slot per cycle, and records
// for each slot the IFM address of its receptive-field origin and whether it is real.
module lifm_pos_stepper
    import lifm_lowering_feeder_pkg::*;
#(
    parameter int WORD_WIDTH = LF_WORD_WIDTH,
    parameter int ADDR_WIDTH = LF_ADDR_WIDTH,
    parameter int MAX_R_SIZE = LF_MAX_R_SIZE,
    parameter int SLOT_WIDTH = (MAX_R_SIZE > 1) ? $clog2(MAX_R_SIZE) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 run,
    input  logic [SLOT_WIDTH-1:0]                slot,
    input  logic [ADDR_WIDTH-1:0]                p_base,
    input  logic [WORD_WIDTH-1:0]                iw,
    input  logic [WORD_WIDTH-1:0]                ow,
    input  logic [WORD_WIDTH-1:0]                oh,
    input  logic [WORD_WIDTH-1:0]                st,
    output logic [MAX_R_SIZE-1:0][ADDR_WIDTH-1:0] base,
    output logic [MAX_R_SIZE-1:0]                mask
);

    logic [ADDR_WIDTH-1:0] ox_q;
    logic [ADDR_WIDTH-1:0] oy_q;
    logic [ADDR_WIDTH-1:0] ow_ext;
    logic [ADDR_WIDTH-1:0] cur_ox;
    logic [ADDR_WIDTH-1:0] cur_oy;
    logic [ADDR_WIDTH-1:0] p_cur;
    logic [ADDR_WIDTH-1:0] area;
    logic [ADDR_WIDTH-1:0] base_cur;

    // Current slot position: slot 0 is seeded from p_base, later slots come from the stepper.
    always_comb begin
        ow_ext = (ow == '0) ? ADDR_WIDTH'(1) : ADDR_WIDTH'(ow);
        if (slot == '0) begin
            cur_ox = p_base % ow_ext;
            cur_oy = p_base / ow_ext;
        end else begin
            cur_ox = ox_q;
            cur_oy = oy_q;
        end
        p_cur    = p_base + ADDR_WIDTH'(slot);
        area     = ADDR_WIDTH'(oh) * ADDR_WIDTH'(ow);
        base_cur = cur_oy * ADDR_WIDTH'(st) * ADDR_WIDTH'(iw) + cur_ox * ADDR_WIDTH'(st);
    end

    // Record base/mask for this slot and step ox/oy to the next raster position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ox_q <= '0;
            oy_q <= '0;
            base <= '0;
            mask <= '0;
        end else if (run) begin
            base[slot] <= base_cur;
            mask[slot] <= (p_cur < area);
            if ((cur_ox + ADDR_WIDTH'(1)) == ow_ext) begin
                ox_q <= '0;
                oy_q <= cur_oy + ADDR_WIDTH'(1);
            end else begin
                ox_q <= cur_ox + ADDR_WIDTH'(1);
                oy_q <= cur_oy;
            end
        end
    end

endmodule

// File: rtl/lifm_lowering_feeder.sv
// Lowers one IFM channel im2col-style: for every filter tap it reads one word per output
// position of the tile and hands the packed column to the redundancy controller.
module lifm_lowering_feeder
    import lifm_lowering_feeder_pkg::*;
#(
    parameter int WORD_WIDTH = LF_WORD_WIDTH,
    parameter int MAX_R_SIZE = LF_MAX_R_SIZE,
    parameter int ADDR_WIDTH = LF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] iw,
    input  logic [WORD_WIDTH-1:0] ow,
    input  logic [WORD_WIDTH-1:0] oh,
    input  logic [WORD_WIDTH-1:0] fw,
    input  logic [WORD_WIDTH-1:0] fh,
    input  logic [WORD_WIDTH-1:0] st,
    input  logic [ADDR_WIDTH-1:0] p_base,
    output logic                  busy,
    output logic                  done,
    output logic                  ifm_rd_en,
    output logic [ADDR_WIDTH-1:0] ifm_addr,
    input  logic [WORD_WIDTH-1:0] ifm_rdata,
    lifm_lowering_feeder_if.master out_if
);

    localparam int SLOT_WIDTH = (MAX_R_SIZE > 1) ? $clog2(MAX_R_SIZE) : 1;
    localparam logic [SLOT_WIDTH-1:0] SLOT_LAST = SLOT_WIDTH'(MAX_R_SIZE - 1);

    feeder_state_t state_q, state_d;

    logic [WORD_WIDTH-1:0]            iw_q, ow_q, oh_q, fw_q, fh_q, st_q;
    logic [ADDR_WIDTH-1:0]            p_base_q;
    logic [SLOT_WIDTH-1:0]            slot_q;
    logic [WORD_WIDTH-1:0]            kx_q, ky_q, idx_q;
    logic [ADDR_WIDTH-1:0]            row_off_q;
    logic [MAX_R_SIZE*WORD_WIDTH-1:0] line_q;
    logic                             pend_active_q;
    logic [SLOT_WIDTH-1:0]            pend_slot_q;
    logic                             pend_rd_q;
    logic                             out_valid;
    logic [MAX_R_SIZE-1:0][ADDR_WIDTH-1:0] slot_base;
    logic [MAX_R_SIZE-1:0]            slot_mask;

    logic slot_last;
    logic last_col;
    logic accept;

    assign slot_last = (slot_q == SLOT_LAST);
    assign last_col  = (kx_q == fw_q - WORD_WIDTH'(1)) && (ky_q == fh_q - WORD_WIDTH'(1));
    assign accept    = (state_q == ST_OUT) && out_if.out_ready;

    assign out_if.out_valid = out_valid;
    assign out_if.idx       = idx_q;
    assign out_if.lifm_line = line_q;
    assign out_if.line_mask = slot_mask;

    lifm_pos_stepper #(
        .WORD_WIDTH (WORD_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_R_SIZE (MAX_R_SIZE),
        .SLOT_WIDTH (SLOT_WIDTH)
    ) u_stepper (
        .clk    (clk),
        .reset  (reset),
        .run    (state_q == ST_SETUP),
        .slot   (slot_q),
        .p_base (p_base_q),
        .iw     (iw_q),
        .ow     (ow_q),
        .oh     (oh_q),
        .st     (st_q),
        .base   (slot_base),
        .mask   (slot_mask)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus status, read-port and handshake outputs.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        ifm_rd_en = 1'b0;
        ifm_addr  = '0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (fw == '0 || fh == '0) ? ST_FIN : ST_SETUP;
                end
            end
            ST_SETUP: begin
                busy = 1'b1;
                if (slot_last) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                busy = 1'b1;
                if (slot_mask[slot_q]) begin
                    ifm_rd_en = 1'b1;
                    ifm_addr  = slot_base[slot_q] + row_off_q + ADDR_WIDTH'(kx_q);
                end
                if (slot_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy    = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_if.out_ready) state_d = last_col ? ST_FIN : ST_FETCH;
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Config latch, slot counter, read-data capture and filter-tap walk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iw_q          <= '0;
            ow_q          <= '0;
            oh_q          <= '0;
            fw_q          <= '0;
            fh_q          <= '0;
            st_q          <= '0;
            p_base_q      <= '0;
            slot_q        <= '0;
            kx_q          <= '0;
            ky_q          <= '0;
            idx_q         <= '0;
            row_off_q     <= '0;
            line_q        <= '0;
            pend_active_q <= 1'b0;
            pend_slot_q   <= '0;
            pend_rd_q     <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                iw_q     <= iw;
                ow_q     <= ow;
                oh_q     <= oh;
                fw_q     <= fw;
                fh_q     <= fh;
                st_q     <= (st == '0) ? WORD_WIDTH'(1) : st;
                p_base_q <= p_base;
            end

            if (state_q == ST_SETUP || state_q == ST_FETCH) begin
                slot_q <= slot_last ? '0 : slot_q + SLOT_WIDTH'(1);
            end else begin
                slot_q <= '0;
            end

            pend_active_q <= (state_q == ST_FETCH);
            pend_slot_q   <= slot_q;
            pend_rd_q     <= ifm_rd_en;
            if (pend_active_q) begin
                line_q[pend_slot_q*WORD_WIDTH +: WORD_WIDTH] <= pend_rd_q ? ifm_rdata : '0;
            end

            if (state_q == ST_SETUP) begin
                kx_q      <= '0;
                ky_q      <= '0;
                row_off_q <= '0;
                idx_q     <= '0;
            end else if (accept && !last_col) begin
                if (kx_q == fw_q - WORD_WIDTH'(1)) begin
                    kx_q      <= '0;
                    ky_q      <= ky_q + WORD_WIDTH'(1);
                    row_off_q <= row_off_q + ADDR_WIDTH'(iw_q);
                end else begin
                    kx_q <= kx_q + WORD_WIDTH'(1);
                end
                idx_q <= idx_q + WORD_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_lifm_lowering_feeder.sv
// Scoreboard bench for the LIFM lowering feeder: a tap/position model fills queues of
// expected reads and columns, and a monitor checks the DUT against them as they appear.
module tb_lifm_lowering_feeder;
    import lifm_lowering_feeder_pkg::*;

    localparam int W = 8;
    localparam int R = 4;
    localparam int A = 16;

    typedef struct {
        logic [W-1:0]   idx;
        logic [R*W-1:0] line;
        logic [R-1:0]   mask;
    } col_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] iw, ow, oh, fw, fh, st;
    logic [A-1:0] p_base;
    logic         busy, done, ifm_rd_en;
    logic [A-1:0] ifm_addr;
    logic [W-1:0] ifm_rdata;

    lifm_lowering_feeder_if #(.WORD_WIDTH(W), .MAX_R_SIZE(R)) out_if ();

    lifm_lowering_feeder #(.WORD_WIDTH(W), .MAX_R_SIZE(R), .ADDR_WIDTH(A)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .iw        (iw),
        .ow        (ow),
        .oh        (oh),
        .fw        (fw),
        .fh        (fh),
        .st        (st),
        .p_base    (p_base),
        .busy      (busy),
        .done      (done),
        .ifm_rd_en (ifm_rd_en),
        .ifm_addr  (ifm_addr),
        .ifm_rdata (ifm_rdata),
        .out_if    (out_if)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem [0:65535];
    col_t         exp_q[$];
    logic [A-1:0] addr_q[$];
    int           checks = 0;
    int           errors = 0;
    int           done_cnt = 0;
    int           ready_mode = 0;
    bit           stall_done = 0;
    bit           prev_acc = 0;
    col_t         mon_col;
    logic [A-1:0] mon_addr;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: every tap (ky,kx) gives one column; each real output position
    // (oy,ox) of the tile reads IFM word (oy*st+ky)*iw + ox*st + kx.
    task automatic build_model(input int m_iw, m_ow, m_oh, m_fw, m_fh, m_st, m_pb);
        int ste;
        ste = (m_st == 0) ? 1 : m_st;
        for (int ky = 0; ky < m_fh; ky++) begin
            for (int kx = 0; kx < m_fw; kx++) begin
                col_t c;
                c.idx  = W'(ky * m_fw + kx);
                c.line = '0;
                c.mask = '0;
                for (int r = 0; r < R; r++) begin
                    int p;
                    p = (m_pb + r) & 16'hFFFF;
                    if (p < m_oh * m_ow) begin
                        int oy, ox;
                        logic [A-1:0] a;
                        oy = p / m_ow;
                        ox = p % m_ow;
                        a  = A'((oy * ste + ky) * m_iw + ox * ste + kx);
                        addr_q.push_back(a);
                        c.mask[r] = 1'b1;
                        c.line    = line_slot_set(c.line, r, mem[a]);
                    end
                end
                exp_q.push_back(c);
            end
        end
    endtask

    // IFM read port with one cycle of latency; idle cycles return junk.
    always @(posedge clk) begin
        ifm_rdata <= ifm_rd_en ? mem[ifm_addr] : W'($urandom);
    end

    // Monitor: compare every read address and every accepted column against the queues.
    always @(negedge clk) begin
        if (reset) begin
            prev_acc = 1'b0;
        end else begin
            if (prev_acc) check_output("valid_drop_after_accept", out_if.out_valid, 0);
            prev_acc = out_if.out_valid && out_if.out_ready;
            if (ifm_rd_en) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_read actual=%0h expected=none", ifm_addr);
                end else begin
                    mon_addr = addr_q.pop_front();
                    check_output("ifm_addr", ifm_addr, mon_addr);
                end
            end
            if (prev_acc) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_column actual_idx=%0d expected=none", out_if.idx);
                end else begin
                    mon_col = exp_q.pop_front();
                    check_output("idx", out_if.idx, mon_col.idx);
                    check_output("lifm_line", out_if.lifm_line, mon_col.line);
                    check_output("line_mask", out_if.line_mask, mon_col.mask);
                end
            end
            if (done) done_cnt++;
        end
    end

    // Consumer ready: always high, random, or a 5-cycle stall on column idx 3.
    initial begin
        out_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: out_if.out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (!stall_done && out_if.out_valid && out_if.idx == 3 && exp_q.size() > 0) begin
                        stall_done = 1'b1;
                        out_if.out_ready = 1'b0;
                        for (int k = 0; k < 5; k++) begin
                            @(posedge clk);
                            #1;
                            check_output("stall_valid", out_if.out_valid, 1);
                            check_output("stall_idx", out_if.idx, exp_q[0].idx);
                            check_output("stall_line", out_if.lifm_line, exp_q[0].line);
                            check_output("stall_mask", out_if.line_mask, exp_q[0].mask);
                            check_output("stall_no_read", ifm_rd_en, 0);
                        end
                    end
                    out_if.out_ready = 1'b1;
                end
                default: out_if.out_ready = 1'b1;
            endcase
        end
    end

    task automatic apply_stimulus(input int t_iw, t_ow, t_oh, t_fw, t_fh, t_st, t_pb);
        @(negedge clk);
        iw = W'(t_iw); ow = W'(t_ow); oh = W'(t_oh);
        fw = W'(t_fw); fh = W'(t_fh); st = W'(t_st);
        p_base = A'(t_pb);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_tile(input int t_iw, t_ow, t_oh, t_fw, t_fh, t_st, t_pb, input bit extra_start);
        int d0;
        bit seen;
        d0   = done_cnt;
        seen = 1'b0;
        build_model(t_iw, t_ow, t_oh, t_fw, t_fh, t_st, t_pb);
        apply_stimulus(t_iw, t_ow, t_oh, t_fw, t_fh, t_st, t_pb);
        check_output("busy_after_start", busy, (t_fw != 0 && t_fh != 0));
        if (done) seen = 1'b1;
        if (extra_start && !seen) begin
            iw = 8'hFF; ow = 8'h09; oh = 8'h09; fw = 8'h05; fh = 8'h05; st = 8'h03;
            p_base = A'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (done) seen = 1'b1;
        end
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_output("done_seen", seen, 1);
        check_output("busy_at_done", busy, 0);
        if (extra_start) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("done_one_cycle", done, 0);
        check_output("done_count", done_cnt - d0, 1);
        check_output("columns_left", exp_q.size(), 0);
        check_output("reads_left", addr_q.size(), 0);
        if (extra_start) begin
            @(negedge clk);
            check_output("start_in_fin_ignored", busy, 0);
        end
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 65536; i++) mem[i] = W'($urandom);
        reset = 1'b1;
        start = 1'b0;
        iw = '0; ow = '0; oh = '0; fw = '0; fh = '0; st = '0; p_base = '0;

        repeat (3) @(negedge clk);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_rd_en", ifm_rd_en, 0);
        check_output("reset_addr", ifm_addr, 0);
        check_output("reset_valid", out_if.out_valid, 0);
        check_output("reset_idx", out_if.idx, 0);
        check_output("reset_line", out_if.lifm_line, 0);
        check_output("reset_mask", out_if.line_mask, 0);
        reset = 1'b0;

        $display("[TB] directed shapes");
        run_tile(6, 4, 4, 3, 3, 1, 0, 1'b0);
        run_tile(6, 4, 4, 3, 3, 1, 2, 1'b0);
        run_tile(7, 3, 3, 3, 3, 2, 0, 1'b0);
        run_tile(2, 1, 1, 2, 2, 1, 0, 1'b0);

        $display("[TB] backpressure on idx 3");
        ready_mode = 2;
        run_tile(6, 4, 4, 3, 3, 1, 0, 1'b0);
        check_output("stall_happened", stall_done, 1);

        $display("[TB] start while busy and in FIN, empty filter");
        ready_mode = 0;
        run_tile(7, 3, 3, 3, 3, 2, 0, 1'b1);
        run_tile(6, 4, 4, 0, 3, 1, 0, 1'b0);

        $display("[TB] random tiles");
        ready_mode = 1;
        for (int n = 0; n < 8; n++) begin
            int r_ow, r_oh, r_fw, r_fh, r_st, r_iw, r_pb;
            r_ow = $urandom_range(1, 5);
            r_oh = $urandom_range(1, 4);
            r_fw = $urandom_range(1, 3);
            r_fh = $urandom_range(1, 3);
            r_st = $urandom_range(0, 2);
            r_iw = (r_ow - 1) * ((r_st == 0) ? 1 : r_st) + r_fw + $urandom_range(0, 2);
            r_pb = $urandom_range(0, r_ow * r_oh + 1);
            run_tile(r_iw, r_ow, r_oh, r_fw, r_fh, r_st, r_pb, 1'b0);
        end

        $display("[TB] reset during fetch of idx 2");
        ready_mode = 0;
        build_model(6, 4, 4, 3, 3, 1, 0);
        apply_stimulus(6, 4, 4, 3, 3, 1, 0);
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            if (out_if.idx == 2 && ifm_rd_en) found = 1'b1;
        end
        check_output("reached_fetch_idx2", found, 1);
        reset = 1'b1;
        #1;
        check_output("midrst_busy", busy, 0);
        check_output("midrst_done", done, 0);
        check_output("midrst_rd_en", ifm_rd_en, 0);
        check_output("midrst_addr", ifm_addr, 0);
        check_output("midrst_valid", out_if.out_valid, 0);
        check_output("midrst_idx", out_if.idx, 0);
        check_output("midrst_line", out_if.lifm_line, 0);
        check_output("midrst_mask", out_if.line_mask, 0);
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_output("idle_after_reset", busy, 0);
        run_tile(6, 4, 4, 3, 3, 1, 0, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
